// File: rtl/test_add_suite.sv
// test_add_suite: built-in self test that runs four fixed vectors through registered
// scalar add, 4-lane vector add and multiply-add datapaths and checks each result.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset, clears all state
//   fail   - sticky, set once any compare mismatches
//   finish - sticky, set on the edge of the last compare
module test_add_suite #(
  parameter bit INJECT_FAIL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  output logic fail,
  output logic finish
);
  localparam logic [31:0] SA = {8'd200, 8'd255, 8'd127, 8'd3};
  localparam logic [31:0] SB = {8'd100, 8'd1, 8'd1, 8'd5};
  localparam logic [31:0] SY = {8'd44, 8'd0, 8'd128, 8'd8};
  // Expected scalar results; optionally corrupt vector 2 to prove the checker fires.
  localparam logic [31:0] SYX = SY ^ ({31'd0, INJECT_FAIL} << 16);
  localparam logic [31:0] MA = {8'd10, 8'd255, 8'd16, 8'd2};
  localparam logic [31:0] MB = {8'd20, 8'd255, 8'd16, 8'd3};
  localparam logic [31:0] MC = {8'd100, 8'd0, 8'd1, 8'd4};
  localparam logic [31:0] MY = {8'd44, 8'd1, 8'd1, 8'd10};
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] idx;
  logic ld, miss, fail_q, fail_d, finish_q, finish_d, vld1_q, vld2_q;
  logic [7:0] s_a_q, s_b_q, s_e_q, s_e2_q, sres_q;
  logic [7:0] m_a_q, m_b_q, m_c_q, m_e_q, m_e2_q, mres_q, msum;
  logic [31:0] v_a_q, v_b_q, v_e_q, v_e2_q, vres_q, vsum;
  always_comb begin
    cnt_d = (cnt_q == 3'd6) ? cnt_q : cnt_q + 3'd1;
    ld = cnt_q < 3'd4;
    idx = cnt_q[1:0];
    vsum = '0;
    for (int j = 0; j < 4; j++) vsum[8*j +: 8] = v_a_q[8*j +: 8] + v_b_q[8*j +: 8];
    msum = m_a_q * m_b_q + m_c_q;
    miss = vld2_q && (sres_q != s_e2_q || vres_q != v_e2_q || mres_q != m_e2_q);
    fail_d = fail_q | miss;
    finish_d = finish_q | (cnt_q == 3'd5);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      vld1_q <= 1'b0;
      vld2_q <= 1'b0;
      s_a_q <= '0;
      s_b_q <= '0;
      s_e_q <= '0;
      v_a_q <= '0;
      v_b_q <= '0;
      v_e_q <= '0;
      m_a_q <= '0;
      m_b_q <= '0;
      m_c_q <= '0;
      m_e_q <= '0;
      sres_q <= '0;
      vres_q <= '0;
      mres_q <= '0;
      s_e2_q <= '0;
      v_e2_q <= '0;
      m_e2_q <= '0;
      fail_q <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      vld1_q <= ld;
      vld2_q <= vld1_q;
      if (ld) begin
        s_a_q <= SA[8*idx +: 8];
        s_b_q <= SB[8*idx +: 8];
        s_e_q <= SYX[8*idx +: 8];
        // Vector k uses scalar vectors k..k+3 (mod 4) across lanes: a byte rotation.
        v_a_q <= 32'({SA, SA} >> (8*idx));
        v_b_q <= 32'({SB, SB} >> (8*idx));
        v_e_q <= 32'({SY, SY} >> (8*idx));
        m_a_q <= MA[8*idx +: 8];
        m_b_q <= MB[8*idx +: 8];
        m_c_q <= MC[8*idx +: 8];
        m_e_q <= MY[8*idx +: 8];
      end
      sres_q <= s_a_q + s_b_q;
      vres_q <= vsum;
      mres_q <= msum;
      s_e2_q <= s_e_q;
      v_e2_q <= v_e_q;
      m_e2_q <= m_e_q;
      fail_q <= fail_d;
      finish_q <= finish_d;
    end
  end
  assign fail = fail_q;
  assign finish = finish_q;
endmodule

// File: tb/tb_test_add_suite.sv
// tb_test_add_suite: randomized reset/abort sequencing against an edge-count model.
module tb_test_add_suite;
  logic clock, reset;
  logic fail0, finish0, fail1, finish1;
  int n_cmp, n_bad, e;
  int ta[4] = '{3, 127, 255, 200};
  int tb[4] = '{5, 1, 1, 100};
  int ma[4] = '{2, 16, 255, 10};
  int mb[4] = '{3, 16, 255, 20};
  int mc[4] = '{4, 1, 0, 100};
  int lit_s[4] = '{8, 128, 0, 44};
  int lit_m[4] = '{10, 1, 1, 44};

  test_add_suite #(.INJECT_FAIL(1'b0)) dut0 (.clock(clock), .reset(reset), .fail(fail0), .finish(finish0));
  test_add_suite #(.INJECT_FAIL(1'b1)) dut1 (.clock(clock), .reset(reset), .fail(fail1), .finish(finish1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: number of rising edges seen since reset release.
  always @(posedge clock or negedge reset)
    if (!reset) e <= 0;
    else e <= e + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", n, act, exp, e);
    end
  endtask

  always @(negedge clock) begin
    int k;
    logic [31:0] v;
    chk("finish0", {31'd0, finish0}, {31'd0, e >= 6});
    chk("fail0", {31'd0, fail0}, 32'd0);
    chk("finish1", {31'd0, finish1}, {31'd0, e >= 6});
    chk("fail1", {31'd0, fail1}, {31'd0, e >= 5});
    chk("cnt", {29'd0, dut0.cnt_q}, (e > 6) ? 32'd6 : 32'(e));
    if (e >= 2 && e <= 5) begin
      k = e - 2;
      v = '0;
      for (int j = 0; j < 4; j++) v[8*j +: 8] = 8'((ta[(k+j)%4] + tb[(k+j)%4]) % 256);
      chk("sres", {24'd0, dut0.sres_q}, 32'((ta[k] + tb[k]) % 256));
      chk("vres", dut0.vres_q, v);
      chk("mres", {24'd0, dut0.mres_q}, 32'((ma[k] * mb[k] + mc[k]) % 256));
      chk("sres_lit", {24'd0, dut0.sres_q}, 32'(lit_s[k]));
      chk("mres_lit", {24'd0, dut0.mres_q}, 32'(lit_m[k]));
      if (e == 2) chk("vres_lit", dut0.vres_q, 32'h2C008008);
    end
  end

  function automatic int off();
    int r = $urandom_range(1, 8);
    return (r >= 5) ? r + 1 : r;
  endfunction

  task automatic release_rst();
    @(posedge clock);
    #(off());
    reset = 1'b1;
  endtask

  task automatic abort_after(input int n);
    repeat (n - 1) @(posedge clock);
    @(posedge clock);
    #(off());
    reset = 1'b0;
    #1;
    chk("async_fail0", {31'd0, fail0}, 32'd0);
    chk("async_finish0", {31'd0, finish0}, 32'd0);
    chk("async_fail1", {31'd0, fail1}, 32'd0);
    chk("async_finish1", {31'd0, finish1}, 32'd0);
    repeat ($urandom_range(1, 4)) @(posedge clock);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    repeat (16) @(posedge clock);
    release_rst();
    abort_after(130);
    release_rst();
    abort_after(3);
    for (int i = 0; i < 12; i++) begin
      release_rst();
      abort_after($urandom_range(1, 12));
    end
    release_rst();
    repeat (30) @(posedge clock);
    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
